tqvp_rebeccargb_display_scanner: RTL and testbench

TinyQV peripheral that multiplexes up to eight 7-segment digits over two chained 74HC595 shift registers. It sits directly downstream of the universal decoder. Software copies decoded segment bytes from the decoder's output register into an 8-byte frame buffer here. The block then scans those bytes autonomously: it shifts a segment byte plus a one-hot digit-select byte, latches them, and holds for a programmable dwell before moving to the next digit.

---
 rtl/tqvp_rebeccargb_display_scanner_if.sv | 11 +
 rtl/tqvp_rebeccargb_display_scanner.sv | 188 ++++++++++++++++++
 tb/tb_tqvp_rebeccargb_display_scanner.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_rebeccargb_display_scanner_if.sv
// Register bus between the TinyQV core and the display scanner peripheral.
`timescale 1ns/1ps
interface tqvp_rebeccargb_display_scanner_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_rebeccargb_display_scanner.sv
// Scans an 8-byte segment frame buffer out to two chained 74HC595s, one digit at a time,
// with a programmable dwell per digit.
`timescale 1ns/1ps
module tqvp_rebeccargb_display_scanner (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  tqvp_rebeccargb_display_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DWELL = 2'd3
  } state_t;

  logic [7:0]  buf_r [8];
  logic [7:0]  ctrl_r;
  logic [7:0]  dwell_r;
  logic [7:0]  frames_r;
  logic [2:0]  digit_r;
  state_t      state_r;
  logic [15:0] word_r;
  logic [3:0]  bit_cnt_r;
  logic        phase_r;
  logic [11:0] dwell_cnt_r;
  logic        ser_r;
  logic        srclk_r;
  logic        rclk_r;

  state_t      state_s;
  logic [15:0] word_s;
  logic [3:0]  bit_cnt_s;
  logic        phase_s;
  logic [11:0] dwell_cnt_s;
  logic [2:0]  digit_s;
  logic [7:0]  frames_s;
  logic        en_s;
  logic [2:0]  last_s;
  logic        wrap_s;
  logic [2:0]  adv_digit_s;
  logic        unused_s;

  // Shift word is {digit-select byte, segment byte}, each optionally inverted.
  function automatic logic [15:0] build_word(input logic [2:0] digit,
                                             input logic [7:0] ctrl,
                                             input logic [7:0] seg);
    logic [7:0] sel;
    sel = 8'd1 << digit;
    return {sel ^ {8{ctrl[1]}}, seg ^ {8{ctrl[2]}}};
  endfunction

  assign unused_s    = &{1'b0, ui_in};
  assign en_s        = ctrl_r[0];
  assign last_s      = ctrl_r[6:4];
  assign wrap_s      = (digit_r >= last_s);
  assign adv_digit_s = wrap_s ? 3'd0 : (digit_r + 3'd1);

  // Register file writes; read-only and unused addresses drop the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) buf_r[i] <= 8'h00;
      ctrl_r  <= 8'h70;
      dwell_r <= 8'h3F;
    end else if (bus.data_write) begin
      if (!bus.address[3]) begin
        buf_r[bus.address[2:0]] <= bus.data_in;
      end else if (bus.address == 4'h8) begin
        ctrl_r <= bus.data_in & 8'h77;
      end else if (bus.address == 4'h9) begin
        dwell_r <= bus.data_in;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    bus.data_out = 8'h00;
    if (!bus.address[3]) begin
      bus.data_out = buf_r[bus.address[2:0]];
    end else begin
      case (bus.address[2:0])
        3'd0:    bus.data_out = ctrl_r;
        3'd1:    bus.data_out = dwell_r;
        3'd2:    bus.data_out = {(state_r != ST_IDLE), state_r, 2'b00, digit_r};
        3'd3:    bus.data_out = frames_r;
        default: bus.data_out = 8'h00;
      endcase
    end
  end

  // Scan FSM next-state logic.
  always_comb begin
    state_s     = state_r;
    word_s      = word_r;
    bit_cnt_s   = bit_cnt_r;
    phase_s     = phase_r;
    dwell_cnt_s = dwell_cnt_r;
    digit_s     = digit_r;
    frames_s    = frames_r;
    case (state_r)
      ST_IDLE: begin
        if (en_s) begin
          word_s    = build_word(digit_r, ctrl_r, buf_r[digit_r]);
          bit_cnt_s = 4'd0;
          phase_s   = 1'b0;
          state_s   = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!phase_r) begin
          phase_s = 1'b1;
        end else begin
          phase_s = 1'b0;
          word_s  = {word_r[14:0], 1'b0};
          if (bit_cnt_r == 4'd15) begin
            bit_cnt_s = 4'd0;
            state_s   = ST_LATCH;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end
      end
      ST_LATCH: begin
        // (DWELL+1)*16 cycles, counted down to zero inclusive.
        dwell_cnt_s = {dwell_r, 4'hF};
        state_s     = ST_DWELL;
      end
      ST_DWELL: begin
        if (dwell_cnt_r != 12'd0) begin
          dwell_cnt_s = dwell_cnt_r - 12'd1;
        end else begin
          digit_s = adv_digit_s;
          if (wrap_s) begin
            frames_s = frames_r + 8'd1;
          end else begin
            frames_s = frames_r;
          end
          if (en_s) begin
            word_s    = build_word(adv_digit_s, ctrl_r, buf_r[adv_digit_s]);
            bit_cnt_s = 4'd0;
            phase_s   = 1'b0;
            state_s   = ST_SHIFT;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Scan state registers; pin outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      word_r      <= 16'h0000;
      bit_cnt_r   <= 4'd0;
      phase_r     <= 1'b0;
      dwell_cnt_r <= 12'd0;
      digit_r     <= 3'd0;
      frames_r    <= 8'h00;
      ser_r       <= 1'b0;
      srclk_r     <= 1'b0;
      rclk_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      word_r      <= word_s;
      bit_cnt_r   <= bit_cnt_s;
      phase_r     <= phase_s;
      dwell_cnt_r <= dwell_cnt_s;
      digit_r     <= digit_s;
      frames_r    <= frames_s;
      ser_r       <= (state_s == ST_SHIFT) & word_s[15];
      srclk_r     <= (state_s == ST_SHIFT) & phase_s;
      rclk_r      <= (state_s == ST_LATCH);
    end
  end

  assign uo_out = {4'b0000, rclk_r, srclk_r, ser_r, 1'b0};

endmodule

// File: tb/tb_tqvp_rebeccargb_display_scanner.sv
// Directed bench for the display scanner: register map, shift words, timing, frames, disable and reset.
`timescale 1ns/1ps
module tb_tqvp_rebeccargb_display_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  int         n_checks;
  int         n_fails;

  tqvp_rebeccargb_display_scanner_if bus_if();

  tqvp_rebeccargb_display_scanner dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus_if.address    = a;
    bus_if.data_in    = d;
    bus_if.data_write = 1'b1;
    @(posedge clk);
    #1;
    bus_if.data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    bus_if.address = a;
    #0.1;
    d = bus_if.data_out;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // Sample ncyc cycles starting with the current one (cycle 0).
  task automatic watch(input int ncyc, output logic [15:0] word, output int rises,
                       output int first_rise, output int first_rclk, output int rclk_cnt,
                       output int err);
    logic       prev_srclk;
    logic       prev_ser;
    logic [7:0] u;
    word = 16'h0000; rises = 0; first_rise = -1; first_rclk = -1; rclk_cnt = 0; err = 0;
    prev_srclk = 1'b1;
    prev_ser   = uo_out[1];
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) step();
      u = uo_out;
      if ((u & 8'hF1) != 8'h00) err++;
      if (u[2] && !prev_srclk) begin
        word = {word[14:0], u[1]};
        rises++;
        if (first_rise < 0) first_rise = i;
        if (u[1] !== prev_ser) err++;
      end
      if (u[3]) begin
        rclk_cnt++;
        if (first_rclk < 0) first_rclk = i;
      end
      prev_srclk = u[2];
      prev_ser   = u[1];
    end
  endtask

  logic [7:0]  d;
  logic [15:0] w;
  int          rises, first_rise, first_rclk, rclk_cnt, err;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    ui_in    = 8'h00;
    bus_if.address    = 4'h0;
    bus_if.data_in    = 8'h00;
    bus_if.data_write = 1'b0;
    rst_n = 1'b0;
    #12;

    // Reset state
    check("rst_uo", int'(uo_out), 32'h00);
    rd(4'h8, d); check("rst_ctrl", int'(d), 32'h70);
    rd(4'h9, d); check("rst_dwell", int'(d), 32'h3F);
    rd(4'hA, d); check("rst_status", int'(d), 32'h00);
    rd(4'hB, d); check("rst_frames", int'(d), 32'h00);
    rst_n = 1'b1;
    step();

    // Register map
    wr(4'h3, 8'hA5); rd(4'h3, d); check("buf3_rb", int'(d), 32'hA5);
    wr(4'h8, 8'hFE); rd(4'h8, d); check("ctrl_mask", int'(d), 32'h76);
    wr(4'hA, 8'hFF); rd(4'hA, d); check("status_ro", int'(d), 32'h00);
    wr(4'hC, 8'hFF); rd(4'hC, d); check("unused_rd", int'(d), 32'h00);
    wr(4'h9, 8'h12); rd(4'h9, d); check("dwell_rb", int'(d), 32'h12);

    // Single digit then digit 1
    do_reset();
    wr(4'h0, 8'h3F);
    wr(4'h9, 8'h00);
    wr(4'h8, 8'h71);
    step();
    rd(4'hA, d); check("sd_status0", int'(d), 32'hA0);
    watch(49, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("sd_word", int'(w), 32'h013F);
    check("sd_rises", rises, 16);
    check("sd_first_rise", first_rise, 1);
    check("sd_rclk_at", first_rclk, 32);
    check("sd_rclk_len", rclk_cnt, 1);
    check("sd_err", err, 0);
    step();
    watch(49, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("d1_word", int'(w), 32'h0200);
    check("d1_first_rise", first_rise, 1);
    check("d1_err", err, 0);

    // Inversion
    do_reset();
    wr(4'h0, 8'h3F);
    wr(4'h9, 8'h00);
    wr(4'h8, 8'h07);
    step();
    watch(49, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("inv_word", int'(w), 32'hFEC0);
    step();
    rd(4'hB, d); check("inv_frames", int'(d), 32'h01);
    rd(4'hA, d); check("inv_status", int'(d), 32'hA0);

    // Wrap and frame count with LAST=2
    do_reset();
    wr(4'h9, 8'h00);
    wr(4'h8, 8'h21);
    step();
    rd(4'hA, d); check("wrap_d0", int'(d), 32'hA0);
    repeat (49) step();
    rd(4'hA, d); check("wrap_d1", int'(d), 32'hA1);
    repeat (49) step();
    rd(4'hA, d); check("wrap_d2", int'(d), 32'hA2);
    rd(4'hB, d); check("wrap_fr0", int'(d), 32'h00);
    repeat (49) step();
    rd(4'hA, d); check("wrap_d0b", int'(d), 32'hA0);
    rd(4'hB, d); check("wrap_fr1", int'(d), 32'h01);
    repeat (255 * 147 - 1 - 147) step();
    rd(4'hB, d); check("wrap_fr254", int'(d), 32'hFE);
    step();
    rd(4'hB, d); check("wrap_fr255", int'(d), 32'hFF);
    repeat (147) step();
    rd(4'hB, d); check("wrap_fr_roll", int'(d), 32'h00);

    // Disable mid-shift of digit 1
    do_reset();
    wr(4'h9, 8'h00);
    wr(4'h8, 8'h71);
    step();
    watch(49, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("dis_d0_word", int'(w), 32'h0100);
    step();
    repeat (4) step();
    wr(4'h8, 8'h70);
    watch(43, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("dis_rises", rises, 13);
    check("dis_word", int'(w), 32'h0200);
    check("dis_rclk_at", first_rclk, 26);
    check("dis_rclk_len", rclk_cnt, 1);
    rd(4'hA, d); check("dis_dwell_st", int'(d), 32'hE1);
    step();
    rd(4'hA, d); check("dis_idle_st", int'(d), 32'h02);
    watch(100, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("dis_no_srclk", rises, 0);
    check("dis_no_rclk", rclk_cnt, 0);

    // Asynchronous reset between edges mid-shift
    do_reset();
    wr(4'h0, 8'hFF);
    wr(4'h8, 8'h73);
    step();
    step();
    check("ar_pre_uo", int'(uo_out), 32'h06);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_uo", int'(uo_out), 32'h00);
    rd(4'hA, d); check("ar_status", int'(d), 32'h00);
    rd(4'h8, d); check("ar_ctrl", int'(d), 32'h70);
    rst_n = 1'b1;
    step();
    watch(60, w, rises, first_rise, first_rclk, rclk_cnt, err);
    check("ar_no_srclk", rises, 0);
    rd(4'hA, d); check("ar_idle", int'(d), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
